// File: rtl/adbg_crc_seq_if.sv
// Bundle between a debug sub-module's burst FSM / adbg_crc32 instance and adbg_crc_seq.
// err_cnt exists only when ADBG_CRC_SEQ_ERR_CNT_EN is defined.
interface adbg_crc_seq_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start;
  logic                 gen_mode;
  logic [CNT_WIDTH-1:0] word_count;
  logic                 abort;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 crc_clr;
  logic                 crc_en;
  logic                 crc_shift;
  logic                 crc_data;
  logic                 crc_serial;
  logic                 crc_bit_out;
  logic                 busy;
  logic                 done;
  logic                 crc_ok;
`ifdef ADBG_CRC_SEQ_ERR_CNT_EN
  logic [7:0]           err_cnt;

  modport master (
    output start, gen_mode, word_count, abort, bit_valid, bit_in, crc_serial,
    input  crc_clr, crc_en, crc_shift, crc_data, crc_bit_out, busy, done, crc_ok, err_cnt
  );
  modport slave (
    input  start, gen_mode, word_count, abort, bit_valid, bit_in, crc_serial,
    output crc_clr, crc_en, crc_shift, crc_data, crc_bit_out, busy, done, crc_ok, err_cnt
  );
`else
  modport master (
    output start, gen_mode, word_count, abort, bit_valid, bit_in, crc_serial,
    input  crc_clr, crc_en, crc_shift, crc_data, crc_bit_out, busy, done, crc_ok
  );
  modport slave (
    input  start, gen_mode, word_count, abort, bit_valid, bit_in, crc_serial,
    output crc_clr, crc_en, crc_shift, crc_data, crc_bit_out, busy, done, crc_ok
  );
`endif
endinterface

// File: rtl/adbg_crc_seq.sv
// Sequences the serial CRC engine through clear / data / CRC check-or-stream for one debug burst.
// Optional: define ADBG_CRC_SEQ_ERR_CNT_EN to add the saturating failed-check counter err_cnt.
module adbg_crc_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rstn,
  adbg_crc_seq_if.slave  bus
);

  localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned CRC_CNT_W = 5;
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CRC_CNT_W-1:0] CRC_LAST = CRC_CNT_W'(31);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_DATA = 3'd2,
    S_CRC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 gen_q;
  logic [CNT_WIDTH-1:0] wc_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [CNT_WIDTH-1:0] word_cnt_q;
  logic [CRC_CNT_W-1:0] crc_cnt_q;
  logic                 mismatch_q;
  logic                 crc_ok_q;

  logic data_last;
  logic crc_last;
  logic mismatch_d;

  assign data_last  = (bit_cnt_q == LAST_BIT) && (word_cnt_q == wc_q - CNT_WIDTH'(1));
  assign crc_last   = (crc_cnt_q == CRC_LAST);
  assign mismatch_d = mismatch_q | (~gen_q & (bus.bit_in ^ bus.crc_serial));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; abort outranks every strobe
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_CLR;
        S_CLR:  state_d = (wc_q == '0) ? S_CRC : S_DATA;
        S_DATA: if (bus.bit_valid && data_last) state_d = S_CRC;
        S_CRC:  if (bus.bit_valid && crc_last) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Engine controls pass the strobe straight through so the engine sees the bit in the same cycle
  always_comb begin
    bus.crc_clr     = 1'b0;
    bus.crc_en      = 1'b0;
    bus.crc_shift   = 1'b0;
    bus.crc_data    = 1'b0;
    bus.crc_bit_out = 1'b0;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    case (state_q)
      S_IDLE: bus.busy = 1'b0;
      S_CLR:  bus.crc_clr = 1'b1;
      S_DATA: begin
        bus.crc_en   = bus.bit_valid & ~bus.abort;
        bus.crc_data = bus.bit_in;
      end
      S_CRC: begin
        bus.crc_shift   = bus.bit_valid & ~bus.abort;
        bus.crc_bit_out = gen_q & bus.crc_serial;
      end
      S_DONE: bus.done = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.crc_ok = crc_ok_q;

  // Burst configuration, bit/word/CRC counters and check result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_q      <= 1'b0;
      wc_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      crc_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      crc_ok_q   <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (bus.start) begin
        gen_q      <= bus.gen_mode;
        wc_q       <= bus.word_count;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        crc_cnt_q  <= '0;
        mismatch_q <= 1'b0;
        crc_ok_q   <= 1'b0;
      end
    end else if (bus.abort) begin
      crc_ok_q <= 1'b0;
    end else if (bus.bit_valid) begin
      if (state_q == S_DATA) begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_q  <= '0;
          word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
        end else begin
          bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        end
      end else if (state_q == S_CRC) begin
        crc_cnt_q  <= crc_cnt_q + CRC_CNT_W'(1);
        mismatch_q <= mismatch_d;
        if (crc_last) crc_ok_q <= gen_q | ~mismatch_d;
      end
    end
  end

`ifdef ADBG_CRC_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Failed check bursts, saturating; only reset clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= 8'h00;
    end else if (state_q == S_DONE && !bus.abort && !gen_q && mismatch_q && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
